// File: rtl/fwd_operand_mux_if.sv
// Bus bundle for the forwarding operand mux: operand inputs, select/hit
// controls, pipeline controls and the registered result fields.
interface fwd_operand_mux_if #(
   parameter int WIDTH = 32,
   parameter int N     = 3,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
);
   logic [N*WIDTH-1:0] d;
   logic               in_valid;
   logic [SEL_W-1:0]   sel;
   logic [N-1:0]       hit;
   logic               stall;
   logic               flush;
   logic               err_clr;
   logic [WIDTH-1:0]   y;
   logic               out_valid;
   logic [SEL_W-1:0]   src;
   logic               fwd;
   logic               sel_err;
   logic [CNT_W-1:0]   fwd_cnt;

   modport master (
      output d, in_valid, sel, hit, stall, flush, err_clr,
      input  y, out_valid, src, fwd, sel_err, fwd_cnt
   );

   modport slave (
      input  d, in_valid, sel, hit, stall, flush, err_clr,
      output y, out_valid, src, fwd, sel_err, fwd_cnt
   );
endinterface

// File: rtl/fwd_operand_mux.sv
// Registered N-way operand select for the forwarding path: index or priority-hit
// pick, stall/flush control, sticky out-of-range flag and saturating forward count.
module fwd_operand_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 3,
   parameter int SEL_W = 2,
   parameter int MODE  = 0,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   fwd_operand_mux_if.slave bus
);
   localparam int            NSLOT = 2 ** SEL_W;
   localparam logic [SEL_W:0] N_L  = (SEL_W + 1)'(N);

   logic [WIDTH-1:0] d_arr [NSLOT];
   logic [SEL_W-1:0] idx;
   logic             oor;
   logic             load;
   logic             take;
   logic             unused_bits;

   // Slots past N read as zero so every select value maps to a defined word.
   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      if (k < N) begin : g_real
         assign d_arr[k] = bus.d[k*WIDTH +: WIDTH];
      end else begin : g_pad
         assign d_arr[k] = '0;
      end
   end

   assign unused_bits = ^{bus.hit, bus.sel};

   always_comb begin
      idx = '0;
      oor = 1'b0;
      if (MODE == 0) begin
         if ({1'b0, bus.sel} < N_L) idx = bus.sel;
         else                       oor = 1'b1;
      end else begin
         // Walk downward so the lowest (youngest) hitting stage wins.
         for (int k = N - 1; k >= 1; k--) begin
            if (bus.hit[k]) idx = SEL_W'(k);
         end
      end
   end

   assign load = !bus.flush && !bus.stall;
   assign take = load && bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.y         <= '0;
         bus.out_valid <= 1'b0;
         bus.src       <= '0;
         bus.fwd       <= 1'b0;
         bus.sel_err   <= 1'b0;
         bus.fwd_cnt   <= '0;
      end else begin
         if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.fwd       <= 1'b0;
         end else if (!bus.stall) begin
            bus.y         <= d_arr[idx];
            bus.src       <= idx;
            bus.out_valid <= bus.in_valid;
            bus.fwd       <= bus.in_valid && (idx != '0);
         end

         if (take && (idx != '0) && (bus.fwd_cnt != '1))
            bus.fwd_cnt <= bus.fwd_cnt + 1'b1;

         // A new error on the same edge as a clear keeps the flag set.
         if (take && oor)      bus.sel_err <= 1'b1;
         else if (bus.err_clr) bus.sel_err <= 1'b0;
      end
   end
endmodule
